// File: rtl/test_data_stream_ctrl.sv
// test_data_stream_ctrl: sequences a generator/checker test run.
// It re-seeds the generator and checker, streams the requested number of lines, checks the returned lines, then waits for the checker hash to settle.
module test_data_stream_ctrl #(
    parameter int CNT_WIDTH   = 32,
    parameter int CHK_LATENCY = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] num_lines,
    output logic                 gen_reset_n,
    output logic                 gen_next,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    input  logic                 rx_valid,
    output logic                 chk_en,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [CNT_WIDTH-1:0] tx_count,
    output logic [CNT_WIDTH-1:0] rx_count
);
    localparam int SW = $clog2(CHK_LATENCY + 1);
    typedef enum logic [2:0] {IDLE, INIT, RUN, DRAIN, SETTLE, DONE} state_t;
    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] num_q, num_d, tx_q, tx_d, rx_q, rx_d;
    logic [SW-1:0]        set_q, set_d;
    logic                 err_q, err_d, rx_ok;
    always_comb begin
        tx_valid    = reset_n && state_q == RUN && tx_q < num_q;
        gen_next    = tx_valid && tx_ready;
        // A returned line is legal only once it has been sent; rx_q<=tx_q<=num_q always holds.
        rx_ok       = (state_q == RUN || state_q == DRAIN) && rx_q != tx_q;
        chk_en      = reset_n && rx_valid && rx_ok;
        gen_reset_n = reset_n && state_q != INIT;
        busy        = reset_n && state_q inside {INIT, RUN, DRAIN, SETTLE};
        done        = reset_n && state_q == DONE;
        error       = err_q;
        tx_count    = tx_q;
        rx_count    = rx_q;
        state_d     = state_q;
        num_d       = num_q;
        tx_d        = tx_q + CNT_WIDTH'(gen_next);
        rx_d        = rx_q + CNT_WIDTH'(chk_en);
        err_d       = err_q | (rx_valid && !rx_ok);
        set_d       = '0;
        case (state_q)
            IDLE, DONE: if (start) begin
                state_d = INIT;
                num_d   = num_lines;
                tx_d    = '0;
                rx_d    = '0;
                err_d   = 1'b0;
            end
            INIT:    state_d = RUN;
            RUN:     if (tx_q == num_q) state_d = DRAIN;
            DRAIN:   if (rx_d == num_q) state_d = SETTLE;
            SETTLE: begin
                set_d = set_q + 1'b1;
                if (set_q == SW'(CHK_LATENCY - 1)) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            num_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            err_q   <= 1'b0;
            set_q   <= '0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            err_q   <= err_d;
            set_q   <= set_d;
        end
    end
endmodule

// File: tb/tb_test_data_stream_ctrl.sv
// tb_test_data_stream_ctrl: directed bench for test_data_stream_ctrl.
module tb_test_data_stream_ctrl;
    logic        clk = 1'b0;
    logic        reset_n, start, tx_ready, rx_valid;
    logic [31:0] num_lines;
    logic        gen_reset_n, gen_next, tx_valid, chk_en, busy, done, error;
    logic [31:0] tx_count, rx_count;
    int checks = 0, errors = 0;
    int cyc, gens, chks, drops, inits, last_chk, txv_seen;

    test_data_stream_ctrl #(.CNT_WIDTH(32), .CHK_LATENCY(4)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .num_lines(num_lines),
        .gen_reset_n(gen_reset_n), .gen_next(gen_next), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_valid(rx_valid), .chk_en(chk_en), .busy(busy),
        .done(done), .error(error), .tx_count(tx_count), .rx_count(rx_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: tx_ready=1; mode 1: tx_ready alternates 1/0; mode 2: like 0 plus a stray start mid-run.
    // mode 3: like 0 but rx_valid is driven for three cycles from the first sent line instead of echoing.
    task automatic run(input logic [31:0] n, input int mode);
        logic [2:0] pipe = '0;
        int rx_sent = 0;
        num_lines = n;
        start = 1'b1;
        tick();
        start = 1'b0;
        num_lines = 32'hdead_beef;
        cyc = 0; gens = 0; chks = 0; drops = 0; inits = 0; last_chk = -1; txv_seen = 0;
        while (!done && cyc < 200) begin
            tx_ready = (mode == 1) ? ~cyc[0] : 1'b1;
            rx_valid = (mode == 3) ? (gens >= 1 && rx_sent < 3) : pipe[2];
            if (mode == 3 && rx_valid) rx_sent++;
            if (mode == 2 && cyc == 3) begin
                start = 1'b1;
                num_lines = 32'd7;
            end
            #1;
            if (!gen_reset_n) inits++;
            if (inits > 0 && gen_reset_n && gens < int'(n) && !tx_valid) drops++;
            if (tx_valid) txv_seen = 1;
            if (gen_next) gens++;
            if (chk_en) begin
                chks++;
                last_chk = cyc;
            end
            pipe = {pipe[1:0], gen_next};
            tick();
            start = 1'b0;
            rx_valid = 1'b0;
            cyc++;
        end
        chk("run_done_in_budget", done, 1);
        chk("run_init_one_cycle", inits, 1);
        chk("run_busy_low_at_done", busy, 0);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; num_lines = 32'd0; tx_ready = 1'b1; rx_valid = 1'b1;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_gen_next", gen_next, 0);
        chk("rst_chk_en", chk_en, 0);
        chk("rst_gen_reset_n", gen_reset_n, 0);
        chk("rst_tx_count", tx_count, 0);
        chk("rst_rx_count", rx_count, 0);
        reset_n = 1'b1; rx_valid = 1'b0;
        tick();
        chk("idle_gen_reset_n", gen_reset_n, 1);
        chk("idle_busy", busy, 0);

        num_lines = 32'd8;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("init_busy", busy, 1);
        chk("init_gen_reset_n", gen_reset_n, 0);
        chk("init_tx_valid", tx_valid, 0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;

        run(32'd8, 0);
        chk("n8_tx_count", tx_count, 8);
        chk("n8_rx_count", rx_count, 8);
        chk("n8_error", error, 0);
        chk("n8_gen_pulses", gens, 8);
        chk("n8_done_after_last_rx", cyc - last_chk, 5);
        tick();
        chk("n8_done_held", done, 1);
        chk("n8_tx_held", tx_count, 8);

        run(32'd5, 1);
        chk("n5_gen_pulses", gens, 5);
        chk("n5_tx_valid_drops", drops, 0);
        chk("n5_tx_count", tx_count, 5);
        chk("n5_rx_count", rx_count, 5);
        chk("n5_error", error, 0);

        run(32'd0, 0);
        chk("n0_done_cycle", cyc, 7);
        chk("n0_tx_valid_seen", txv_seen, 0);
        chk("n0_tx_count", tx_count, 0);
        chk("n0_rx_count", rx_count, 0);
        chk("n0_error", error, 0);

        run(32'd2, 3);
        chk("n2_rx_count", rx_count, 2);
        chk("n2_chk_pulses", chks, 2);
        chk("n2_error", error, 1);
        chk("n2_tx_count", tx_count, 2);

        num_lines = 32'd10;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_clears_error", error, 0);
        for (int i = 0; i < 20 && tx_count != 32'd3; i++) tick();
        chk("mid_tx_count", tx_count, 3);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_gen_reset_n", gen_reset_n, 0);
        chk("mid_rst_tx_valid", tx_valid, 0);
        tick();
        reset_n = 1'b1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_tx_count", tx_count, 0);
        chk("mid_rst_rx_count", rx_count, 0);
        run(32'd4, 0);
        chk("after_rst_tx_count", tx_count, 4);
        chk("after_rst_rx_count", rx_count, 4);

        run(32'd3, 2);
        chk("stray_start_tx_count", tx_count, 3);
        chk("stray_start_rx_count", rx_count, 3);
        chk("stray_start_gen_pulses", gens, 3);
        chk("stray_start_error", error, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
